sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 152 +++++++++++++++
 tb/tb_sram_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Single-outstanding load/store controller in front of a 32-bit word SRAM.
// Handles byte/half/word alignment, lane steering and load extension.
module sram_ctrl #(
   parameter int DEPTH    = 1024,
   parameter int LOGDEPTH = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [31:0]         req_addr,
   input  logic [1:0]          req_size,
   input  logic                req_signed,
   input  logic [31:0]         req_wdata,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [31:0]         resp_rdata,
   output logic                resp_error,
   output logic                sram_read_req,
   output logic [LOGDEPTH-1:0] sram_read_addr,
   input  logic [31:0]         sram_read_data,
   output logic                sram_write_req,
   output logic [LOGDEPTH-1:0] sram_write_addr,
   output logic [3:0]          sram_write_byte_en,
   output logic [31:0]         sram_write_data
);

   typedef enum logic [1:0] {IDLE, LOAD, RESP} state_t;

   state_t      state_q, state_d;
   logic [1:0]  off_q, off_d;
   logic [1:0]  size_q, size_d;
   logic        sgn_q, sgn_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        valid_q, valid_d;

   logic        accept;
   logic        req_err;
   logic [31:0] shifted;
   logic [31:0] load_ext;

   assign req_ready = reset_n && (state_q == IDLE);
   assign accept    = req_valid && req_ready;

   // Anything above the SRAM's byte span is out of range.
   assign req_err = (req_size == 2'd3)
                 || (req_size == 2'd1 && req_addr[0])
                 || (req_size == 2'd2 && req_addr[1:0] != 2'd0)
                 || (|(req_addr >> (LOGDEPTH + 2)));

   assign sram_read_req   = accept && !req_write && !req_err;
   assign sram_write_req  = accept &&  req_write && !req_err;
   assign sram_read_addr  = req_addr[LOGDEPTH+1:2];
   assign sram_write_addr = req_addr[LOGDEPTH+1:2];

   always_comb begin
      sram_write_byte_en = 4'b1111;
      sram_write_data    = req_wdata;
      case (req_size)
         2'd0: begin
            sram_write_byte_en = 4'b0001 << req_addr[1:0];
            sram_write_data    = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            sram_write_byte_en = 4'b0011 << req_addr[1:0];
            sram_write_data    = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Bring the addressed lane down to bit 0, then extend by captured size.
   assign shifted = sram_read_data >> {off_q, 3'b000};

   always_comb begin
      load_ext = shifted;
      case (size_q)
         2'd0:    load_ext = sgn_q ? {{24{shifted[7]}}, shifted[7:0]}
                                   : {24'd0, shifted[7:0]};
         2'd1:    load_ext = sgn_q ? {{16{shifted[15]}}, shifted[15:0]}
                                   : {16'd0, shifted[15:0]};
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!req_write && !req_err) begin
                  state_d = LOAD;
                  off_d   = req_addr[1:0];
                  size_d  = req_size;
                  sgn_d   = req_signed;
               end else begin
                  state_d = RESP;
                  valid_d = 1'b1;
                  rdata_d = 32'd0;
                  err_d   = req_err;
               end
            end
         end
         LOAD: begin
            state_d = RESP;
            valid_d = 1'b1;
            rdata_d = load_ext;
            err_d   = 1'b0;
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         off_q   <= 2'd0;
         size_q  <= 2'd0;
         sgn_q   <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         off_q   <= off_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   assign resp_valid = valid_q;
   assign resp_rdata = rdata_q;
   assign resp_error = err_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Vector table plus scoreboard for sram_ctrl, with a behavioural SRAM,
// and hand sequences for response back-pressure and reset during a load.
module tb_sram_ctrl;
   localparam int DEPTH    = 1024;
   localparam int LOGDEPTH = $clog2(DEPTH);

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic                req_valid = 1'b0, req_ready;
   logic                req_write = 1'b0;
   logic [31:0]         req_addr = '0;
   logic [1:0]          req_size = '0;
   logic                req_signed = 1'b0;
   logic [31:0]         req_wdata = '0;
   logic                resp_valid, resp_ready = 1'b0;
   logic [31:0]         resp_rdata;
   logic                resp_error;
   logic                sram_read_req, sram_write_req;
   logic [LOGDEPTH-1:0] sram_read_addr, sram_write_addr;
   logic [31:0]         sram_read_data;
   logic [3:0]          sram_write_byte_en;
   logic [31:0]         sram_write_data;

   int n_tests = 0;
   int n_fail  = 0;

   sram_ctrl #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_error(resp_error),
      .sram_read_req(sram_read_req), .sram_read_addr(sram_read_addr),
      .sram_read_data(sram_read_data),
      .sram_write_req(sram_write_req), .sram_write_addr(sram_write_addr),
      .sram_write_byte_en(sram_write_byte_en), .sram_write_data(sram_write_data)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: one-cycle read latency, byte-enabled writes.
   logic [31:0] mem [DEPTH];
   initial begin
      sram_read_data = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
      mem[2] = 32'h1122_3344;
      mem[5] = 32'h80FF_7F01;
      forever begin
         @(posedge clk);
         if (sram_read_req) sram_read_data <= mem[sram_read_addr];
         if (sram_write_req)
            for (int b = 0; b < 4; b++)
               if (sram_write_byte_en[b]) mem[sram_write_addr][8*b +: 8] = sram_write_data[8*b +: 8];
      end
   end

   typedef struct {
      string       name;
      logic        wr;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input string nm, input logic wr, input logic [31:0] addr,
                               input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      vec_t v;
      v.name = nm; v.wr = wr; v.addr = addr; v.size = size; v.sgn = sgn; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
      return v;
   endfunction

   // Issue one request, scramble req_* while busy, collect and score the response.
   task automatic do_vec(input vec_t v);
      exp_t e;
      int   lat;
      logic exp_rd, exp_wr;
      @(negedge clk);
      req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
      req_size = v.size; req_signed = v.sgn; req_wdata = v.wdata;
      #1;
      check({v.name, " req_ready"}, 32'(req_ready), 32'd1);
      exp_rd = !v.wr && !v.exp_err;
      exp_wr =  v.wr && !v.exp_err;
      check({v.name, " rd_strobe"}, 32'(sram_read_req), 32'(exp_rd));
      check({v.name, " wr_strobe"}, 32'(sram_write_req), 32'(exp_wr));
      if (exp_rd) check({v.name, " rd_addr"}, 32'(sram_read_addr), 32'(v.addr[LOGDEPTH+1:2]));
      if (exp_wr) begin
         check({v.name, " wr_addr"}, 32'(sram_write_addr), 32'(v.addr[LOGDEPTH+1:2]));
         check({v.name, " byte_en"}, 32'(sram_write_byte_en), 32'(v.exp_be));
         check({v.name, " wdata"}, sram_write_data, v.exp_wdata);
      end
      e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = exp_rd ? 2 : 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      req_write = 1'($urandom); req_addr = $urandom & 32'h0000_0FFC;
      req_size = 2'd2; req_wdata = $urandom;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         check({v.name, " busy ready"}, 32'(req_ready), 32'd0);
         check({v.name, " busy strobes"}, 32'({sram_read_req, sram_write_req}), 32'd0);
      end while (!resp_valid && lat < 8);
      e = sb.pop_front();
      check({v.name, " latency"}, 32'(lat), 32'(e.lat));
      check({v.name, " rdata"}, resp_rdata, e.rdata);
      check({v.name, " error"}, 32'(resp_error), 32'(e.err));
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   vec_t vecs[17];

   initial begin
      vecs[0]  = mk("ld_b_s_16",  0, 32'h16,  2'd0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);
      vecs[1]  = mk("ld_b_u_16",  0, 32'h16,  2'd0, 0, 0, 32'h0000_00FF, 0, 0, 0);
      vecs[2]  = mk("ld_b_s_14",  0, 32'h14,  2'd0, 1, 0, 32'h0000_0001, 0, 0, 0);
      vecs[3]  = mk("ld_h_s_16",  0, 32'h16,  2'd1, 1, 0, 32'hFFFF_80FF, 0, 0, 0);
      vecs[4]  = mk("ld_h_u_14",  0, 32'h14,  2'd1, 0, 0, 32'h0000_7F01, 0, 0, 0);
      vecs[5]  = mk("st_h_0a",    1, 32'h0A,  2'd1, 0, 32'h0000_BEEF, 0, 0, 4'b1100, 32'hBEEF_BEEF);
      vecs[6]  = mk("ld_w_08",    0, 32'h08,  2'd2, 0, 0, 32'hBEEF_3344, 0, 0, 0);
      vecs[7]  = mk("ld_w_mis",   0, 32'h02,  2'd2, 0, 0, 0, 1, 0, 0);
      vecs[8]  = mk("st_h_mis",   1, 32'h03,  2'd1, 0, 32'h1234, 0, 1, 0, 0);
      vecs[9]  = mk("size3",      0, 32'h00,  2'd3, 0, 0, 0, 1, 0, 0);
      vecs[10] = mk("ld_oor",     0, 32'h1000, 2'd2, 0, 0, 0, 1, 0, 0);
      vecs[11] = mk("st_w_ffc",   1, 32'hFFC, 2'd2, 0, 32'hCAFE_F00D, 0, 0, 4'b1111, 32'hCAFE_F00D);
      vecs[12] = mk("ld_w_ffc",   0, 32'hFFC, 2'd2, 0, 0, 32'hCAFE_F00D, 0, 0, 0);
      vecs[13] = mk("st_b_15",    1, 32'h15,  2'd0, 0, 32'h0000_00A5, 0, 0, 4'b0010, 32'hA5A5_A5A5);
      vecs[14] = mk("ld_h_s_14b", 0, 32'h14,  2'd1, 1, 0, 32'hFFFF_A501, 0, 0, 0);
      vecs[15] = mk("ld_b_s_17",  0, 32'h17,  2'd0, 1, 0, 32'hFFFF_FF80, 0, 0, 0);
      vecs[16] = mk("ld_w_14",    0, 32'h14,  2'd2, 0, 0, 32'h80FF_A501, 0, 0, 0);

      // Reset state, with a request pending on the inputs.
      req_valid = 1'b1; req_addr = 32'h14; req_size = 2'd2;
      #12;
      check("rst resp_valid", 32'(resp_valid), 32'd0);
      check("rst rdata", resp_rdata, 32'd0);
      check("rst error", 32'(resp_error), 32'd0);
      check("rst req_ready", 32'(req_ready), 32'd0);
      check("rst strobes", 32'({sram_read_req, sram_write_req}), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      reset_n = 1'b1;

      for (int i = 0; i < 17; i++) do_vec(vecs[i]);

      // Back-pressure: response must hold while resp_ready stays low.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h16; req_size = 2'd0; req_signed = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("bp valid", 32'(resp_valid), 32'd1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp hold valid", 32'(resp_valid), 32'd1);
         check("bp hold rdata", resp_rdata, 32'h0000_00FF);
         check("bp hold error", 32'(resp_error), 32'd0);
         check("bp hold ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      do_vec(mk("bp_next", 1, 32'h20, 2'd2, 0, 32'h5555_AAAA, 0, 0, 4'b1111, 32'h5555_AAAA));

      // Reset while a load is in flight: response is dropped.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h08; req_size = 2'd2;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("rl resp_valid", 32'(resp_valid), 32'd0);
      check("rl req_ready", 32'(req_ready), 32'd0);
      check("rl rd_strobe", 32'(sram_read_req), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("rl no resp", 32'(resp_valid), 32'd0);
         check("rl ready", 32'(req_ready), 32'd1);
      end
      do_vec(mk("post_rst", 0, 32'h20, 2'd2, 0, 0, 32'h5555_AAAA, 0, 0, 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got hang expected finish");
      $fatal(1);
   end

endmodule
